// File: rtl/writeback_buffer.sv
// Write-back FIFO between execute/memory producers and the 8 x 10-bit register file.
// Optional decode forwarding of pending values is enabled by defining WB_FORWARD_EN.
module writeback_buffer #(
   parameter int DATA_W = 10,
   parameter int REG_W  = 3,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [REG_W-1:0]         wb_reg,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     rf_hold,
   output logic [REG_W-1:0]         write_reg,
   output logic [DATA_W-1:0]        write_data,
   output logic                     reg_write_en,
   output logic [$clog2(DEPTH):0]   wb_count
`ifdef WB_FORWARD_EN
   ,
   input  logic [REG_W-1:0]         read_reg1,
   input  logic [REG_W-1:0]         read_reg2,
   output logic                     fwd1_hit,
   output logic                     fwd2_hit,
   output logic [DATA_W-1:0]        fwd1_data,
   output logic [DATA_W-1:0]        fwd2_data
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [REG_W-1:0]  reg_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W:0]    count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign full         = (count == (PTR_W+1)'(DEPTH));
   assign empty        = (count == '0);
   assign wb_ready     = !full;
   assign wb_count     = count;
   assign push         = wb_valid && wb_ready && !reset;
   assign reg_write_en = !empty && !rf_hold;
   assign pop          = reg_write_en;
   assign write_reg    = empty ? '0 : reg_mem[head];
   assign write_data   = empty ? '0 : data_mem[head];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; an entry is only observable once count covers it.
   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem[tail]  <= wb_reg;
         data_mem[tail] <= wb_data;
      end
   end

`ifdef WB_FORWARD_EN
   logic [PTR_W-1:0] idx;

   // Scan oldest to youngest so the last match seen is the youngest pending value.
   // NOTE: every output gets a default first so this block never infers a latch.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd2_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_data = '0;
      idx       = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((PTR_W+1)'(i) < count) begin
            if (reg_mem[idx] == read_reg1) begin
               fwd1_hit  = 1'b1;
               fwd1_data = data_mem[idx];
            end
            if (reg_mem[idx] == read_reg2) begin
               fwd2_hit  = 1'b1;
               fwd2_data = data_mem[idx];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_writeback_buffer;

   localparam int DATA_W = 10;
   localparam int REG_W  = 3;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [REG_W-1:0]  r;
      logic [DATA_W-1:0] d;
   } entry_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              wb_valid;
   logic              wb_ready;
   logic [REG_W-1:0]  wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              rf_hold;
   logic [REG_W-1:0]  write_reg;
   logic [DATA_W-1:0] write_data;
   logic              reg_write_en;
   logic [$clog2(DEPTH):0] wb_count;
`ifdef WB_FORWARD_EN
   logic [REG_W-1:0]  read_reg1;
   logic [REG_W-1:0]  read_reg2;
   logic              fwd1_hit;
   logic              fwd2_hit;
   logic [DATA_W-1:0] fwd1_data;
   logic [DATA_W-1:0] fwd2_data;
`endif

   int     tests = 0;
   int     fails = 0;
   entry_t model_q[$];
   entry_t commit_log[$];

   always #5 clk = ~clk;

   writeback_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_reg       (wb_reg),
      .wb_data      (wb_data),
      .rf_hold      (rf_hold),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .reg_write_en (reg_write_en),
      .wb_count     (wb_count)
`ifdef WB_FORWARD_EN
      ,
      .read_reg1    (read_reg1),
      .read_reg2    (read_reg2),
      .fwd1_hit     (fwd1_hit),
      .fwd2_hit     (fwd2_hit),
      .fwd1_data    (fwd1_data),
      .fwd2_data    (fwd2_data)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, compare against the
   // model mid-cycle, then advance the model across the rising edge.
   task automatic step(input logic rst, input logic v, input logic [REG_W-1:0] r,
                       input logic [DATA_W-1:0] d, input logic h,
                       input logic [REG_W-1:0] rr1, input logic [REG_W-1:0] rr2);
      logic exp_en;
      logic do_push;
      @(negedge clk);
      reset    = rst;
      wb_valid = v;
      wb_reg   = r;
      wb_data  = d;
      rf_hold  = h;
`ifdef WB_FORWARD_EN
      read_reg1 = rr1;
      read_reg2 = rr2;
`endif
      #1;
      exp_en = (model_q.size() != 0) && !h;
      check("reg_write_en", 32'(reg_write_en), 32'(exp_en));
      check("write_reg",  32'(write_reg),  model_q.size() != 0 ? 32'(model_q[0].r) : 32'd0);
      check("write_data", 32'(write_data), model_q.size() != 0 ? 32'(model_q[0].d) : 32'd0);
      check("wb_ready", 32'(wb_ready), 32'(model_q.size() < DEPTH));
      check("wb_count", 32'(wb_count), 32'(model_q.size()));
`ifdef WB_FORWARD_EN
      begin
         logic hit1, hit2;
         logic [DATA_W-1:0] dat1, dat2;
         hit1 = 1'b0; hit2 = 1'b0; dat1 = '0; dat2 = '0;
         for (int k = model_q.size() - 1; k >= 0; k--) begin
            if (!hit1 && model_q[k].r == rr1) begin hit1 = 1'b1; dat1 = model_q[k].d; end
            if (!hit2 && model_q[k].r == rr2) begin hit2 = 1'b1; dat2 = model_q[k].d; end
         end
         check("fwd1_hit",  32'(fwd1_hit),  32'(hit1));
         check("fwd1_data", 32'(fwd1_data), 32'(dat1));
         check("fwd2_hit",  32'(fwd2_hit),  32'(hit2));
         check("fwd2_data", 32'(fwd2_data), 32'(dat2));
      end
`else
      if (rr1 != rr2) begin end
`endif
      if (reg_write_en === 1'b1) commit_log.push_back('{r: write_reg, d: write_data});
      do_push = v && !rst && (model_q.size() < DEPTH);
      @(posedge clk);
      if (rst) begin
         model_q.delete();
      end else begin
         if (exp_en) void'(model_q.pop_front());
         if (do_push) model_q.push_back('{r: r, d: d});
      end
   endtask

   task automatic push_op(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d, input logic h);
      step(1'b0, 1'b1, r, d, h, '0, '0);
   endtask

   task automatic idle(input logic h);
      step(1'b0, 1'b0, '0, '0, h, '0, '0);
   endtask

   initial begin
      reset = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; rf_hold = 1'b0;
`ifdef WB_FORWARD_EN
      read_reg1 = '0; read_reg2 = '0;
`endif
      repeat (2) @(posedge clk);
      model_q.delete();
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

      // Three back-to-back pushes drain one cycle behind, in order.
      commit_log.delete();
      push_op(3'd0, 10'd1, 1'b0);
      push_op(3'd1, 10'd2, 1'b0);
      push_op(3'd2, 10'd4, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("stream_commits", 32'(commit_log.size()), 32'd3);
      if (commit_log.size() == 3) begin
         check("stream_c0", {commit_log[0].r, 19'd0, commit_log[0].d}, {3'd0, 19'd0, 10'd1});
         check("stream_c1", {commit_log[1].r, 19'd0, commit_log[1].d}, {3'd1, 19'd0, 10'd2});
         check("stream_c2", {commit_log[2].r, 19'd0, commit_log[2].d}, {3'd2, 19'd0, 10'd4});
      end

      // Hold the register file: four of five requests fit, then release.
      commit_log.delete();
      for (int i = 0; i < 5; i++) push_op(REG_W'(i + 3), DATA_W'(100 + i), 1'b1);
      check("hold_full_ready", 32'(wb_ready), 32'd0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      idle(1'b0);
      check("hold_release_commits", 32'(commit_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < commit_log.size(); i++)
         check("hold_release_data", 32'(commit_log[i].d), 32'(100 + i));

      // Full FIFO popping with a request waiting: push only on the following edge.
      for (int i = 0; i < 4; i++) push_op(REG_W'(i), DATA_W'(200 + i), 1'b1);
      push_op(3'd7, 10'd300, 1'b0);
      #1 check("full_pop_count", 32'(wb_count), 32'd3);
      push_op(3'd7, 10'd300, 1'b0);
      #1 check("full_next_count", 32'(wb_count), 32'd3);
      for (int i = 0; i < 4; i++) idle(1'b0);

`ifdef WB_FORWARD_EN
      // Youngest of two pending writes to r3 is forwarded; r5 misses.
      push_op(3'd3, 10'd8, 1'b1);
      push_op(3'd3, 10'd16, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1, 3'd3, 3'd5);
      @(negedge clk);
      #1;
      check("fwd_young_hit",  32'(fwd1_hit),  32'd1);
      check("fwd_young_data", 32'(fwd1_data), 32'd16);
      check("fwd_miss_hit",   32'(fwd2_hit),  32'd0);
      check("fwd_miss_data",  32'(fwd2_data), 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b0);
`endif

      // Reset with three entries pending drops all of them.
      push_op(3'd1, 10'd501, 1'b1);
      push_op(3'd2, 10'd502, 1'b1);
      push_op(3'd3, 10'd503, 1'b1);
      commit_log.delete();
      step(1'b1, 1'b1, 3'd4, 10'd504, 1'b1, '0, '0);
      #1;
      check("rst_count", 32'(wb_count), 32'd0);
      check("rst_ready", 32'(wb_ready), 32'd1);
      check("rst_en",    32'(reg_write_en), 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b0);
      check("rst_no_commits", 32'(commit_log.size()), 32'd0);

      // Random traffic with occasional resets against the model.
      for (int n = 0; n < 400; n++) begin
         logic rst, v, h;
         rst = ($urandom_range(0, 39) == 0);
         h   = rst ? 1'b1 : ($urandom_range(0, 2) == 0);
         v   = ($urandom_range(0, 9) < 7);
         step(rst, v, REG_W'($urandom), DATA_W'($urandom), h,
              REG_W'($urandom), REG_W'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
